al_accel_elw_wb: RTL and testbench

Write-back stage directly downstream of the accelerator element-wise unit `al_accel_elw_unit`. It accepts the unit's 8-bit quantized/activated results one byte per handshake and packs them little-endian into 32-bit words. Each word is written to SoC memory over the native `mem_valid`/`mem_ready` bus, starting at a programmed base address. A partial final word is written with byte strobes, and a one-cycle `done` pulse reports completion to the accelerator controller.

---
 rtl/al_accel_pkg.sv | 30 +++
 rtl/al_accel_wb_fifo.sv | 73 +++++++
 rtl/al_accel_elw_wb.sv | 159 +++++++++++++++
 tb/tb_al_accel_elw_wb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/al_accel_pkg.sv
// Shared definitions for the accelerator write-back path.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package al_accel_pkg;

    // Result bytes packed into one memory word.
    localparam int BYTES_PER_WORD = 4;

    // Write-back sequencer states.
    typedef enum logic [2:0] {
        WB_IDLE  = 3'd0,
        WB_PACK  = 3'd1,
        WB_FLUSH = 3'd2,
        WB_DRAIN = 3'd3,
        WB_DONE  = 3'd4
    } wb_state_t;

    // Strobes for a partial word holding 'lanes' valid low-order bytes.
    function automatic logic [3:0] partial_strb(input logic [1:0] lanes);
        logic [3:0] strb;
        case (lanes)
            2'd0:    strb = 4'b0000;
            2'd1:    strb = 4'b0001;
            2'd2:    strb = 4'b0011;
            default: strb = 4'b0111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/al_accel_wb_fifo.sv
// Packed-word FIFO between the byte packer and the memory write port.
// Latency: a push is visible at head_o / empty_o on the cycle after the push edge.
// Backpressure: full_o high refuses pushes; pops of an empty FIFO are ignored.
// Ports: clk/rst; push_i + push_dat_i write; pop_i consumes head_o;
//        full_o/empty_o registered flags; cnt_o current occupancy.
module al_accel_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic [PW:0]   cnt_d;
    logic          full_q;
    logic          empty_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (PW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/al_accel_elw_wb.sv
// Packs element-wise result bytes little-endian into 32-bit words and writes them to memory.
// Latency: 4th byte accepted at edge N -> mem_valid in cycle N+1; done the cycle after the last write.
// Backpressure: elew_do_rdy drops when the FIFO is full and the next byte would complete a word.
// Ports: cfg_start/cfg_base_addr/cfg_num_bytes job setup; elew_do_* byte stream in;
//        mem_* native write bus out; busy level and done pulse to the controller.
module al_accel_elw_wb
    import al_accel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_base_addr,
    input  logic [CNT_W-1:0] cfg_num_bytes,
    input  logic             elew_do_vld,
    input  logic [7:0]       elew_do,
    output logic             elew_do_rdy,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    output logic             busy,
    output logic             done
);
    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int FIFO_W = WORD_W + BYTES_PER_WORD;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    wb_state_t         state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [31:0]       addr_q, addr_d;

    logic              push;
    logic [FIFO_W-1:0] push_dat;
    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic              accept;
    logic              pop;

    al_accel_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .cnt_o      (fifo_cnt)
    );

    // Bytes in lanes 0..2 only sit in the assembly register, so they may be
    // taken while the FIFO is full; only the word-completing byte must wait.
    assign elew_do_rdy = (state_q == WB_PACK) && (rem_q != '0) &&
                         !(fifo_full && (lane_q == 2'd3));
    assign accept      = elew_do_vld & elew_do_rdy;

    assign mem_valid = ~fifo_empty;
    assign pop       = mem_valid & mem_ready;
    assign mem_addr  = addr_q;
    // Stale FIFO contents are hidden while no write is offered.
    assign mem_wdata = mem_valid ? fifo_head[WORD_W-1:0] : '0;
    assign mem_wstrb = mem_valid ? fifo_head[FIFO_W-1:WORD_W] : '0;

    assign busy = (state_q != WB_IDLE);
    assign done = (state_q == WB_DONE);

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        rem_d    = rem_q;
        asm_d    = asm_q;
        addr_d   = addr_q;
        push     = 1'b0;
        push_dat = '0;

        if (pop) begin
            addr_d = addr_q + 32'd4;
        end

        case (state_q)
            WB_IDLE: begin
                if (cfg_start) begin
                    addr_d  = cfg_base_addr & 32'hFFFF_FFFC;
                    rem_d   = cfg_num_bytes;
                    lane_d  = 2'd0;
                    asm_d   = '0;
                    state_d = (cfg_num_bytes == '0) ? WB_DONE : WB_PACK;
                end
            end
            WB_PACK: begin
                if (accept) begin
                    asm_d[{lane_q, 3'b000} +: 8] = elew_do;
                    lane_d = lane_q + 2'd1;
                    rem_d  = rem_q - CNT_W'(1);
                    if (lane_q == 2'd3) begin
                        // Completed word goes out on the same edge, incoming byte included.
                        push     = 1'b1;
                        push_dat = {4'hF, elew_do, asm_q[23:0]};
                        asm_d    = '0;
                    end
                    if (rem_q == CNT_W'(1)) begin
                        state_d = (lane_q == 2'd3) ? WB_DRAIN : WB_FLUSH;
                    end
                end else if (rem_q == '0) begin
                    state_d = (lane_q == 2'd0) ? WB_DRAIN : WB_FLUSH;
                end
            end
            WB_FLUSH: begin
                if (!fifo_full) begin
                    push     = 1'b1;
                    push_dat = {partial_strb(lane_q), asm_q};
                    asm_d    = '0;
                    lane_d   = 2'd0;
                    state_d  = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                // Leave on the edge that retires the final word so done follows it directly.
                if (fifo_empty || (pop && (fifo_cnt == CW'(1)))) begin
                    state_d = WB_DONE;
                end
            end
            WB_DONE: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WB_IDLE;
            lane_q  <= 2'd0;
            rem_q   <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_al_accel_elw_wb.sv
// Directed bench for al_accel_elw_wb: packing, partial words, stalls, zero-length jobs,
// asynchronous reset and ignored restarts. A passive logger records memory writes,
// accepted bytes and done pulses; the linear sequence below checks them.
module tb_al_accel_elw_wb;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start;
    logic [31:0]      cfg_base_addr;
    logic [CNT_W-1:0] cfg_num_bytes;
    logic             elew_do_vld;
    logic [7:0]       elew_do;
    logic             elew_do_rdy;
    logic             mem_valid;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    al_accel_elw_wb #(
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_bytes (cfg_num_bytes),
        .elew_do_vld   (elew_do_vld),
        .elew_do       (elew_do),
        .elew_do_rdy   (elew_do_rdy),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .done          (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [67:0] wlog[$];
    int done_cnt    = 0;
    int valid_cnt   = 0;
    int acc_cnt     = 0;
    int cyc         = 0;
    int last_hs_cyc = 0;
    int done_cyc    = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_valid && mem_ready) begin
                wlog.push_back({mem_addr, mem_wdata, mem_wstrb});
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (mem_valid) valid_cnt = valid_cnt + 1;
            if (elew_do_vld && elew_do_rdy) acc_cnt = acc_cnt + 1;
        end
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wlog.delete();
        done_cnt  = 0;
        valid_cnt = 0;
        acc_cnt   = 0;
    endtask

    task automatic start_job(input logic [31:0] base, input int n);
        cfg_start     = 1'b1;
        cfg_base_addr = base;
        cfg_num_bytes = CNT_W'(n);
        @(posedge clk); #1;
        cfg_start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        elew_do_vld = 1'b1;
        elew_do     = b;
        while (!elew_do_rdy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("rdy_timeout", 32'(elew_do_rdy), 32'd1);
        @(posedge clk); #1;
        elew_do_vld = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt);
        int t = 0;
        while (done_cnt == start_cnt && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt == start_cnt) check("done_timeout", 32'(done_cnt), 32'(start_cnt + 1));
    endtask

    task automatic check_write(input int idx, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        logic [67:0] e;
        if (idx < wlog.size()) begin
            e = wlog[idx];
            check($sformatf("wr%0d_addr", idx), e[67:36], a);
            check($sformatf("wr%0d_data", idx), e[35:4], d);
            check($sformatf("wr%0d_strb", idx), {28'd0, e[3:0]}, {28'd0, s});
        end else begin
            check($sformatf("wr%0d_missing", idx), 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_rdy"},   32'(elew_do_rdy), 32'd0);
        check({pfx, "_valid"}, 32'(mem_valid),   32'd0);
        check({pfx, "_addr"},  mem_addr,         32'd0);
        check({pfx, "_wdata"}, mem_wdata,        32'd0);
        check({pfx, "_wstrb"}, 32'(mem_wstrb),   32'd0);
        check({pfx, "_busy"},  32'(busy),        32'd0);
        check({pfx, "_done"},  32'(done),        32'd0);
    endtask

    initial begin
        int hold_bad;
        int t;

        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_num_bytes = '0;
        elew_do_vld   = 1'b0;
        elew_do       = '0;
        mem_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Eight bytes, memory always ready: two full words.
        clear_log();
        start_job(32'h1000_0000, 8);
        check("t1_rdy_after_start", 32'(elew_do_rdy), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'((i + 1) * 17));
        check("t1_valid_after_4th", 32'(mem_valid), 32'd1);
        check("t1_head_addr", mem_addr, 32'h1000_0000);
        check("t1_head_data", mem_wdata, 32'h4433_2211);
        check("t1_head_strb", 32'(mem_wstrb), 32'hF);
        for (int i = 4; i < 8; i++) send_byte(8'((i + 1) * 17));
        wait_done(0);
        repeat (3) begin @(posedge clk); #1; end
        check("t1_nwrites", 32'(wlog.size()), 32'd2);
        check_write(0, 32'h1000_0000, 32'h4433_2211, 4'hF);
        check_write(1, 32'h1000_0004, 32'h8877_6655, 4'hF);
        check("t1_done_pulses", 32'(done_cnt), 32'd1);
        check("t1_done_latency", 32'(done_cyc - last_hs_cyc), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_done_end", 32'(done), 32'd0);

        // Six bytes with a second start mid-job: partial last word, restart ignored.
        clear_log();
        start_job(32'h5000_0000, 6);
        send_byte(8'h11);
        send_byte(8'h22);
        start_job(32'h6000_0000, 2);
        check("t2_busy_after_restart", 32'(busy), 32'd1);
        check("t2_rdy_after_restart", 32'(elew_do_rdy), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        wait_done(0);
        repeat (3) begin @(posedge clk); #1; end
        check("t2_nwrites", 32'(wlog.size()), 32'd2);
        check_write(0, 32'h5000_0000, 32'h4433_2211, 4'hF);
        check_write(1, 32'h5000_0004, 32'h0000_6655, 4'h3);
        check("t2_accepted", 32'(acc_cnt), 32'd6);
        check("t2_done_pulses", 32'(done_cnt), 32'd1);

        // Memory stalled for 30 cycles while 32 bytes are offered.
        clear_log();
        mem_ready = 1'b0;
        start_job(32'h3000_0000, 32);
        hold_bad    = 0;
        elew_do_vld = 1'b1;
        for (int c = 0; c < 30; c++) begin
            elew_do = 8'(acc_cnt);
            @(posedge clk); #1;
            if (mem_valid && (mem_addr !== 32'h3000_0000 || mem_wdata !== 32'h0302_0100 ||
                              mem_wstrb !== 4'hF)) hold_bad++;
        end
        check("t3_accepted_in_stall", 32'(acc_cnt), 32'd19);
        check("t3_rdy_in_stall", 32'(elew_do_rdy), 32'd0);
        check("t3_valid_in_stall", 32'(mem_valid), 32'd1);
        check("t3_head_held", 32'(hold_bad), 32'd0);
        mem_ready = 1'b1;
        t = 0;
        while (acc_cnt < 32 && t < 300) begin
            elew_do = 8'(acc_cnt);
            @(posedge clk); #1;
            t++;
        end
        elew_do_vld = 1'b0;
        check("t3_accepted_total", 32'(acc_cnt), 32'd32);
        wait_done(0);
        repeat (3) begin @(posedge clk); #1; end
        check("t3_nwrites", 32'(wlog.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check_write(k, 32'h3000_0000 + 32'(4 * k),
                        {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)}, 4'hF);
        end
        check("t3_done_pulses", 32'(done_cnt), 32'd1);

        // Zero-length job.
        clear_log();
        start_job(32'h7000_0000, 0);
        check("t4_done_now", 32'(done), 32'd1);
        check("t4_busy_now", 32'(busy), 32'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("t4_done_pulses", 32'(done_cnt), 32'd1);
        check("t4_no_valid", 32'(valid_cnt), 32'd0);
        check("t4_busy_end", 32'(busy), 32'd0);

        // Asynchronous reset mid-transfer with a write pending, then a fresh job.
        clear_log();
        mem_ready = 1'b0;
        start_job(32'h4000_0000, 8);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hB0 + i));
        check("t5_pending_before_rst", 32'(mem_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        clear_log();
        start_job(32'h2000_0003, 4);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        wait_done(0);
        repeat (3) begin @(posedge clk); #1; end
        check("t5_nwrites", 32'(wlog.size()), 32'd1);
        check_write(0, 32'h2000_0000, 32'hA4A3_A2A1, 4'hF);
        check("t5_done_pulses", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
